// File: rtl/parking_request_queue.sv
// ============================================================================
// parking_request_queue: FIFO of BCD-plate entry/exit requests feeding a lot
// controller via a four-state issue FSM, with a bypass path for leak alarms.
// Revision: 1.0
// ============================================================================
`default_nettype none

module parking_request_queue #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] req_plate,
  input  logic        req_in,
  input  logic        req_out,
  input  logic        req_leak,
  input  logic [2:0]  req_leak_floor,
  input  logic        lot_busy,
  output logic [15:0] license_plate,
  output logic        in_mode,
  output logic        out_mode,
  output logic        leakage,
  output logic [2:0]  leakage_floor,
  output logic [3:0]  queue_count,
  output logic        queue_full,
  output logic        drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [3:0]    DEPTH_C    = 4'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [16:0]    mem [DEPTH];

  logic        plate_ok;
  logic        start_issue;
  logic        push;
  logic        pop;
  logic [16:0] head;
  logic [3:0]  count_next;

  always_comb begin
    plate_ok    = (req_plate[15:12] <= 4'd9) && (req_plate[11:8] <= 4'd9) &&
                  (req_plate[7:4]   <= 4'd9) && (req_plate[3:0]  <= 4'd9);
    // A forwarded leak alarm takes priority over issuing on the same edge.
    start_issue = (state == IDLE) && (queue_count != 4'd0) && !lot_busy && !req_leak;
    pop         = start_issue;
    push        = (req_in ^ req_out) && plate_ok && ((queue_count != DEPTH_C) || pop);
    head        = mem[rd_ptr];
    count_next  = queue_count + {3'b000, push} - {3'b000, pop};
  end

  // Storage holds {plate, dir}; dir=1 is an entry request.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {req_plate, req_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      queue_count   <= 4'd0;
      queue_full    <= 1'b0;
      drop          <= 1'b0;
      leakage       <= 1'b0;
      leakage_floor <= 3'd0;
      license_plate <= 16'd0;
      in_mode       <= 1'b0;
      out_mode      <= 1'b0;
    end else begin
      drop          <= (req_in | req_out) && !push;
      leakage       <= req_leak;
      leakage_floor <= req_leak ? req_leak_floor : 3'd0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      queue_count   <= count_next;
      queue_full    <= (count_next == DEPTH_C);
      license_plate <= 16'd0;
      in_mode       <= 1'b0;
      out_mode      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_issue) begin
            state         <= ISSUE;
            license_plate <= head[16:1];
            in_mode       <= head[0];
            out_mode      <= !head[0];
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
          timer <= '0;
        end
        WAIT_ACK: begin
          if (lot_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TIMER_LAST) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!lot_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parking_request_queue.sv
// ============================================================================
// tb_parking_request_queue: directed self-checking bench for the request queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_parking_request_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req_plate = 16'd0;
  logic        req_in = 1'b0;
  logic        req_out = 1'b0;
  logic        req_leak = 1'b0;
  logic [2:0]  req_leak_floor = 3'd0;
  logic        lot_busy = 1'b0;
  logic [15:0] license_plate;
  logic        in_mode;
  logic        out_mode;
  logic        leakage;
  logic [2:0]  leakage_floor;
  logic [3:0]  queue_count;
  logic        queue_full;
  logic        drop;

  int checks = 0;
  int failures = 0;

  parking_request_queue #(.DEPTH(4), .ACK_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .req_plate(req_plate), .req_in(req_in),
    .req_out(req_out), .req_leak(req_leak), .req_leak_floor(req_leak_floor),
    .lot_busy(lot_busy), .license_plate(license_plate), .in_mode(in_mode),
    .out_mode(out_mode), .leakage(leakage), .leakage_floor(leakage_floor),
    .queue_count(queue_count), .queue_full(queue_full), .drop(drop)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    req_in = 1'b0; req_out = 1'b0; req_leak = 1'b0;
    req_leak_floor = 3'd0; req_plate = 16'd0;
  endtask

  task automatic do_reset;
    clear_inputs();
    lot_busy = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if ({license_plate, in_mode, out_mode, leakage, leakage_floor, queue_count, queue_full, drop} !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs: got plate=%h in=%b out=%b leak=%b fl=%0d cnt=%0d full=%b drop=%b expected all 0",
               license_plate, in_mode, out_mode, leakage, leakage_floor, queue_count, queue_full, drop);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_issue;
    do_reset();
    req_in = 1'b1; req_plate = 16'h9423;
    tick();
    clear_inputs();
    checks++;
    if (queue_count !== 4'd1 || in_mode !== 1'b0) begin
      failures++;
      $display("FAIL single_push: got cnt=%0d in=%b expected cnt=1 in=0", queue_count, in_mode);
    end
    tick();
    checks++;
    if (in_mode !== 1'b1 || out_mode !== 1'b0 || license_plate !== 16'h9423 || queue_count !== 4'd0) begin
      failures++;
      $display("FAIL single_issue: got in=%b out=%b plate=%h cnt=%0d expected in=1 out=0 plate=9423 cnt=0",
               in_mode, out_mode, license_plate, queue_count);
    end
    tick();
    checks++;
    if (in_mode !== 1'b0 || license_plate !== 16'h0000) begin
      failures++;
      $display("FAIL single_pulse_end: got in=%b plate=%h expected in=0 plate=0000", in_mode, license_plate);
    end
  endtask

  task automatic test_full;
    logic [15:0] plates [5];
    plates[0] = 16'h1111; plates[1] = 16'h2222; plates[2] = 16'h3333;
    plates[3] = 16'h4444; plates[4] = 16'h5555;
    do_reset();
    lot_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_in = 1'b1; req_plate = plates[i];
      tick();
      clear_inputs();
      checks++;
      if (queue_count !== ((i < 4) ? 4'(i + 1) : 4'd4) || queue_full !== (i >= 3) || drop !== (i == 4)) begin
        failures++;
        $display("FAIL fill_%0d: got cnt=%0d full=%b drop=%b expected cnt=%0d full=%b drop=%b",
                 i, queue_count, queue_full, drop, (i < 4) ? i + 1 : 4, i >= 3, i == 4);
      end
    end
    // Push into a full queue on the same edge the head is issued.
    lot_busy = 1'b0;
    req_in = 1'b1; req_plate = 16'h6666;
    tick();
    clear_inputs();
    checks++;
    if (queue_count !== 4'd4 || queue_full !== 1'b1 || drop !== 1'b0 || in_mode !== 1'b1 || license_plate !== 16'h1111) begin
      failures++;
      $display("FAIL full_push_pop: got cnt=%0d full=%b drop=%b in=%b plate=%h expected cnt=4 full=1 drop=0 in=1 plate=1111",
               queue_count, queue_full, drop, in_mode, license_plate);
    end
  endtask

  task automatic test_bad_request;
    do_reset();
    lot_busy = 1'b1;
    req_in = 1'b1; req_plate = 16'h1234;
    tick();
    req_plate = 16'h8A54;
    tick();
    checks++;
    if (drop !== 1'b1 || queue_count !== 4'd1) begin
      failures++;
      $display("FAIL bad_digit: got drop=%b cnt=%0d expected drop=1 cnt=1", drop, queue_count);
    end
    req_out = 1'b1; req_plate = 16'h5678;
    tick();
    checks++;
    if (drop !== 1'b1 || queue_count !== 4'd1) begin
      failures++;
      $display("FAIL both_dirs: got drop=%b cnt=%0d expected drop=1 cnt=1", drop, queue_count);
    end
    req_in = 1'b0;
    tick();
    clear_inputs();
    checks++;
    if (drop !== 1'b0 || queue_count !== 4'd2) begin
      failures++;
      $display("FAIL exit_push: got drop=%b cnt=%0d expected drop=0 cnt=2", drop, queue_count);
    end
  endtask

  task automatic test_leak_defer;
    do_reset();
    req_in = 1'b1; req_plate = 16'h4321;
    tick();
    clear_inputs();
    req_leak = 1'b1; req_leak_floor = 3'd3;
    tick();
    clear_inputs();
    checks++;
    if (leakage !== 1'b1 || leakage_floor !== 3'd3 || in_mode !== 1'b0 || queue_count !== 4'd1) begin
      failures++;
      $display("FAIL leak_forward: got leak=%b fl=%0d in=%b cnt=%0d expected leak=1 fl=3 in=0 cnt=1",
               leakage, leakage_floor, in_mode, queue_count);
    end
    tick();
    checks++;
    if (leakage !== 1'b0 || leakage_floor !== 3'd0 || in_mode !== 1'b1 || license_plate !== 16'h4321) begin
      failures++;
      $display("FAIL leak_deferred_issue: got leak=%b fl=%0d in=%b plate=%h expected leak=0 fl=0 in=1 plate=4321",
               leakage, leakage_floor, in_mode, license_plate);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    req_in = 1'b1; req_plate = 16'h1234;
    tick();
    req_in = 1'b0; req_out = 1'b1; req_plate = 16'h5678;
    tick();
    clear_inputs();
    checks++;
    if (in_mode !== 1'b1 || license_plate !== 16'h1234 || queue_count !== 4'd1) begin
      failures++;
      $display("FAIL timeout_first: got in=%b plate=%h cnt=%0d expected in=1 plate=1234 cnt=1",
               in_mode, license_plate, queue_count);
    end
    // One ISSUE-exit edge plus four unacknowledged WAIT_ACK edges.
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (in_mode !== 1'b0 || out_mode !== 1'b0 || license_plate !== 16'h0000) begin
        failures++;
        $display("FAIL timeout_quiet_%0d: got in=%b out=%b plate=%h expected 0 0 0000",
                 i, in_mode, out_mode, license_plate);
      end
    end
    tick();
    checks++;
    if (out_mode !== 1'b1 || in_mode !== 1'b0 || license_plate !== 16'h5678 || queue_count !== 4'd0) begin
      failures++;
      $display("FAIL timeout_next: got out=%b in=%b plate=%h cnt=%0d expected out=1 in=0 plate=5678 cnt=0",
               out_mode, in_mode, license_plate, queue_count);
    end
  endtask

  task automatic test_reset_mid_command;
    do_reset();
    req_in = 1'b1; req_plate = 16'h1111;
    tick();
    clear_inputs();
    tick();
    lot_busy = 1'b1;
    tick();
    req_in = 1'b1; req_plate = 16'h2222;
    tick();
    req_plate = 16'h3333; req_leak = 1'b1; req_leak_floor = 3'd5;
    tick();
    clear_inputs();
    checks++;
    if (queue_count !== 4'd2 || leakage !== 1'b1 || leakage_floor !== 3'd5) begin
      failures++;
      $display("FAIL pre_reset: got cnt=%0d leak=%b fl=%0d expected cnt=2 leak=1 fl=5", queue_count, leakage, leakage_floor);
    end
    reset = 1'b1;
    #2;
    checks++;
    if ({license_plate, in_mode, out_mode, leakage, leakage_floor, queue_count, queue_full, drop} !== 28'd0) begin
      failures++;
      $display("FAIL async_reset: got plate=%h in=%b out=%b leak=%b fl=%0d cnt=%0d full=%b drop=%b expected all 0",
               license_plate, in_mode, out_mode, leakage, leakage_floor, queue_count, queue_full, drop);
    end
    reset = 1'b0;
    lot_busy = 1'b0;
    req_out = 1'b1; req_plate = 16'h7777;
    tick();
    clear_inputs();
    checks++;
    if (queue_count !== 4'd1 || drop !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_push: got cnt=%0d drop=%b expected cnt=1 drop=0", queue_count, drop);
    end
    tick();
    checks++;
    if (out_mode !== 1'b1 || license_plate !== 16'h7777 || queue_count !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_issue: got out=%b plate=%h cnt=%0d expected out=1 plate=7777 cnt=0",
               out_mode, license_plate, queue_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_full();
    test_bad_request();
    test_leak_defer();
    test_timeout();
    test_reset_mid_command();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
